multicycle_ctrl: RTL and testbench

- Control FSM for the multi-cycle variant of the MIPS datapath, which has one shared instruction/data memory and a single ALU reused across cycles.
- Takes the opcode from the instruction register and a memory-ready handshake.
- Produces per-cycle datapath enables and mux selects, replacing the single-cycle opcode decoder on this path.
- Also counts retired instructions and traps on unsupported opcodes.

---
 rtl/multicycle_pkg.sv | 61 ++++++
 rtl/multicycle_ctrl_mem_wait_timer.sv | 41 ++++
 rtl/multicycle_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: opcode values,
// ALU control classes, mux-select encodings, the state enum and the
// DECODE dispatch helper.
package multicycle_pkg;

  // Opcode field IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // ALU control classes
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StExecR   = 4'd3,
    StWbR     = 4'd4,
    StExecI   = 4'd5,
    StWbI     = 4'd6,
    StMemAddr = 4'd7,
    StMemRd   = 4'd8,
    StWbMem   = 4'd9,
    StMemWr   = 4'd10,
    StBranch  = 4'd11,
    StJump    = 4'd12,
    StTrap    = 4'd13
  } state_e;

  // State that follows DECODE for a given opcode; unknown opcodes trap.
  function automatic state_e decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:       return StExecR;
      OP_ADDI, OP_SLTI: return StExecI;
      OP_LW, OP_SW:   return StMemAddr;
      OP_BEQ:         return StBranch;
      OP_J:           return StJump;
      default:        return StTrap;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory wait timer: counts cycles spent waiting for memory and flags the
// cycle in which the count reaches MEM_WAIT_MAX (0 disables the flag).
//   clk, rst : clock, async active-high reset
//   clr      : clear the count (entry into a memory-wait state)
//   inc      : this cycle is a wait cycle (in wait state, memory not ready)
//   expire   : this wait cycle brings the count to MEM_WAIT_MAX
module mem_wait_timer #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int unsigned CntW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // inc already excludes ready cycles, so a completing access never expires.
  assign expire = (MEM_WAIT_MAX != 0) && inc && (cnt_q == CntW'(MEM_WAIT_MAX - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM. Moore-decoded datapath controls from state,
// except FETCH, whose IR/PC writes and exit are qualified by mem_ready_i.
// Counts retired instructions, traps on unsupported opcodes and memory
// timeouts.
//   clk_i, rst_i           : clock, async active-high reset
//   run_i                  : start fetching (sampled in IDLE only)
//   instr_op_i             : IR[31:26], valid from DECODE onward
//   mem_ready_i            : memory completes current access
//   pc_write_o .. pc_source_o : datapath enables and mux selects
//   state_o                : current state (debug)
//   illegal_o, timeout_o   : sticky trap causes
//   retired_o              : retired-instruction count (wraps)
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic [5:0]       instr_op_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_write_cond_o,
  output logic             i_or_d_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic [1:0]       pc_source_o,
  output logic [3:0]       state_o,
  output logic             illegal_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] retired_o
);

  state_e state_q, state_d;
  logic   illegal_q, timeout_q;
  logic [CNT_W-1:0] retired_q;
  logic   retire, expire, waiting, wait_inc, wait_clr, entering_wait;

  assign waiting  = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign wait_inc = waiting && !mem_ready_i;
  assign entering_wait = (state_d == StFetch) || (state_d == StMemRd) || (state_d == StMemWr);
  assign wait_clr = entering_wait && (state_d != state_q);

  mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_timer (
    .clk   (clk_i),
    .rst   (rst_i),
    .clr   (wait_clr),
    .inc   (wait_inc),
    .expire(expire)
  );

  always_comb begin
    state_d         = state_q;
    retire          = 1'b0;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRCB_REG;
    alu_op_o        = ALU_ADD;
    pc_source_o     = PCSRC_ALU;
    unique case (state_q)
      StIdle: begin
        if (run_i) state_d = StFetch;
      end
      StFetch: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = StDecode;
        end else if (expire) begin
          state_d = StTrap;
        end
      end
      StDecode: begin
        // Branch target precompute while the opcode is being dispatched.
        alu_src_b_o = SRCB_IMM_SH2;
        state_d     = decode_next(instr_op_i);
      end
      StExecR: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_RTYPE;
        state_d     = StWbR;
      end
      StWbR: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        retire      = 1'b1;
        state_d     = StFetch;
      end
      StExecI: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = (instr_op_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_d     = StWbI;
      end
      StWbI: begin
        reg_write_o = 1'b1;
        retire      = 1'b1;
        state_d     = StFetch;
      end
      StMemAddr: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        state_d     = (instr_op_i == OP_LW) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
        if (mem_ready_i) state_d = StWbMem;
        else if (expire) state_d = StTrap;
      end
      StWbMem: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        retire       = 1'b1;
        state_d      = StFetch;
      end
      StMemWr: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
        if (mem_ready_i) begin
          retire  = 1'b1;
          state_d = StFetch;
        end else if (expire) begin
          state_d = StTrap;
        end
      end
      StBranch: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALU_SUB;
        pc_write_cond_o = 1'b1;
        pc_source_o     = PCSRC_ALUOUT;
        retire          = 1'b1;
        state_d         = StFetch;
      end
      StJump: begin
        pc_write_o  = 1'b1;
        pc_source_o = PCSRC_JUMP;
        retire      = 1'b1;
        state_d     = StFetch;
      end
      StTrap: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode && state_d == StTrap) illegal_q <= 1'b1;
      if (expire) timeout_q <= 1'b1;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  assign state_o   = state_q;
  assign illegal_o = illegal_q;
  assign timeout_o = timeout_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl. An instruction-level model turns a
// random program (opcodes plus per-access memory latencies) into a per-cycle
// input schedule and the per-cycle control word expected from it. A driver
// replays the schedule; a monitor pops and compares one word per cycle.
module tb_multicycle_ctrl;
  import multicycle_pkg::*;

  localparam int WAIT_MAX = 15;

  typedef struct packed {
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctl_t;

  typedef struct packed {
    ctl_t        c;
    logic [3:0]  st;
    logic        ill, to;
    logic [15:0] ret;
  } obs_t;

  typedef struct packed {
    logic rst, run, rdy;
    logic [5:0] op;
  } stim_t;

  logic clk = 1'b0, rst = 1'b1, run = 1'b0, mem_ready = 1'b0;
  logic [5:0] op = '0;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic reg_dst, mem_to_reg, reg_write, alu_src_a, illegal, timeout;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic [15:0] retired;

  multicycle_ctrl #(.MEM_WAIT_MAX(WAIT_MAX), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .instr_op_i(op), .mem_ready_i(mem_ready),
    .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .i_or_d_o(i_or_d),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .ir_write_o(ir_write),
    .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
    .pc_source_o(pc_source), .state_o(state), .illegal_o(illegal),
    .timeout_o(timeout), .retired_o(retired)
  );

  always #5 clk = ~clk;

  stim_t in_q[$];
  obs_t  exp_q[$];
  int    checks = 0, failures = 0, cyc = 0;
  bit    started = 1'b0;

  // Architectural model state
  int m_ret = 0;
  bit m_ill = 1'b0, m_to = 1'b0;

  logic [5:0] legal [7] = '{OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_J};

  function automatic logic rr();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic bit is_legal(input logic [5:0] o);
    foreach (legal[i]) if (legal[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  // Mostly short latencies, sometimes the last non-timing-out value, sometimes a timeout.
  function automatic int pick_dly();
    int k = $urandom_range(0, 24);
    if (k == 0) return WAIT_MAX - 1;
    if (k == 1) return WAIT_MAX + $urandom_range(0, 2);
    return $urandom_range(0, 3);
  endfunction

  task automatic emit_full(input state_e st, input ctl_t c, input logic rn, input logic rdy,
                           input logic [5:0] o, input logic r);
    stim_t s;
    obs_t  e;
    s.rst = r; s.run = rn; s.rdy = rdy; s.op = o;
    e.c = c; e.st = st; e.ill = m_ill; e.to = m_to; e.ret = 16'(m_ret);
    in_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic emit(input state_e st, input ctl_t c, input logic rdy, input logic [5:0] o);
    emit_full(st, c, rr(), rdy, o, 1'b0);
  endtask

  task automatic do_reset(input int n);
    m_ret = 0; m_ill = 1'b0; m_to = 1'b0;
    repeat (n) emit_full(StIdle, '0, rr(), rr(), 6'($urandom), 1'b1);
  endtask

  task automatic start(input int idle_n);
    repeat (idle_n) emit_full(StIdle, '0, 1'b0, rr(), 6'($urandom), 1'b0);
    emit_full(StIdle, '0, 1'b1, rr(), 6'($urandom), 1'b0);
  endtask

  task automatic trap_phase(input int n);
    repeat (n) emit(StTrap, '0, rr(), 6'($urandom));
  endtask

  // A memory access taking dly not-ready cycles; WAIT_MAX of them is a timeout.
  task automatic mem_phase(input state_e st, input ctl_t c_wait, input ctl_t c_done,
                           input int dly, input logic [5:0] o, input bit retire_done,
                           output bit timed_out);
    int n = (dly >= WAIT_MAX) ? WAIT_MAX : dly;
    repeat (n) emit(st, c_wait, 1'b0, o);
    if (dly >= WAIT_MAX) begin
      m_to = 1'b1;
      timed_out = 1'b1;
    end else begin
      emit(st, c_done, 1'b1, o);
      if (retire_done) m_ret++;
      timed_out = 1'b0;
    end
  endtask

  // One instruction; stop=1 when the machine ends up trapped or aborted.
  task automatic do_instr(input logic [5:0] o, input int fdly, input int mdly,
                          input int abort_wr, output bit stop);
    ctl_t c, w;
    bit   to;
    stop = 1'b0;
    w = '0; w.mem_read = 1'b1; w.alu_src_b = SRCB_FOUR; w.alu_op = ALU_ADD;
    c = w; c.ir_write = 1'b1; c.pc_write = 1'b1;
    mem_phase(StFetch, w, c, fdly, 6'($urandom), 1'b0, to);
    if (to) begin stop = 1'b1; return; end
    c = '0; c.alu_src_b = SRCB_IMM_SH2; c.alu_op = ALU_ADD;
    emit(StDecode, c, rr(), o);
    case (o)
      OP_RTYPE: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = SRCB_REG; c.alu_op = ALU_RTYPE;
        emit(StExecR, c, rr(), o);
        c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1;
        emit(StWbR, c, rr(), o);
        m_ret++;
      end
      OP_ADDI, OP_SLTI: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM;
        c.alu_op = (o == OP_SLTI) ? ALU_SLT : ALU_ADD;
        emit(StExecI, c, rr(), o);
        c = '0; c.reg_write = 1'b1;
        emit(StWbI, c, rr(), o);
        m_ret++;
      end
      OP_LW, OP_SW: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_ADD;
        emit(StMemAddr, c, rr(), o);
        w = '0; w.i_or_d = 1'b1;
        if (o == OP_LW) w.mem_read = 1'b1;
        else w.mem_write = 1'b1;
        if (o == OP_SW && abort_wr > 0) begin
          repeat (abort_wr) emit(StMemWr, w, 1'b0, o);
          stop = 1'b1;
          return;
        end
        mem_phase((o == OP_LW) ? StMemRd : StMemWr, w, w, mdly, o, o == OP_SW, to);
        if (to) stop = 1'b1;
        else if (o == OP_LW) begin
          c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
          emit(StWbMem, c, rr(), o);
          m_ret++;
        end
      end
      OP_BEQ: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = SRCB_REG; c.alu_op = ALU_SUB;
        c.pc_write_cond = 1'b1; c.pc_source = PCSRC_ALUOUT;
        emit(StBranch, c, rr(), o);
        m_ret++;
      end
      OP_J: begin
        c = '0; c.pc_write = 1'b1; c.pc_source = PCSRC_JUMP;
        emit(StJump, c, rr(), o);
        m_ret++;
      end
      default: begin
        m_ill = 1'b1;
        stop = 1'b1;
      end
    endcase
  endtask

  // Monitor: one expected word per driven cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (started && exp_q.size() > 0) begin
      obs_t e, a;
      e = exp_q.pop_front();
      a.c = '{pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
              reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
      a.st = state; a.ill = illegal; a.to = timeout; a.ret = retired;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle%0d ctl: state got=%0d want=%0d ctl got=%h want=%h ill/to got=%b%b want=%b%b retired got=%0d want=%0d",
                 cyc, a.st, e.st, a.c, e.c, a.ill, a.to, e.ill, e.to, a.ret, e.ret);
      end
      cyc++;
    end
  end

  initial begin
    bit t;
    int n;
    logic [5:0] o;

    // Directed program
    do_reset(2);
    start(1);
    do_instr(OP_RTYPE, 0, 0, 0, t);
    do_instr(OP_LW, 0, 3, 0, t);
    do_instr(OP_BEQ, 1, 0, 0, t);
    do_instr(OP_J, 0, 0, 0, t);
    do_instr(OP_SW, WAIT_MAX - 1, WAIT_MAX - 1, 0, t);  // ready on the limit cycle completes
    do_instr(OP_ADDI, 2, 0, 0, t);
    do_instr(OP_SLTI, 0, 0, 0, t);
    do_instr(6'd63, 0, 0, 0, t);
    trap_phase(20);
    do_reset(1);
    // Fetch timeout
    start(0);
    do_instr(OP_RTYPE, WAIT_MAX, 0, 0, t);
    trap_phase(4);
    do_reset(1);
    // MEM_RD timeout
    start(0);
    do_instr(OP_J, 0, 0, 0, t);
    do_instr(OP_LW, 0, WAIT_MAX + 5, 0, t);
    trap_phase(3);
    do_reset(1);
    // Asynchronous reset during a store
    start(0);
    do_instr(OP_ADDI, 0, 0, 0, t);
    do_instr(OP_SW, 0, 0, 2, t);
    do_reset(1);

    // Random program segments
    repeat (8) begin
      start($urandom_range(0, 2));
      n = $urandom_range(5, 15);
      t = 1'b0;
      for (int i = 0; i < n && !t; i++) begin
        o = legal[$urandom_range(0, 6)];
        do_instr(o, pick_dly(), pick_dly(), 0, t);
      end
      if (!t) begin
        do o = 6'($urandom); while (is_legal(o));
        do_instr(o, $urandom_range(0, 2), 0, 0, t);
      end
      trap_phase($urandom_range(1, 5));
      do_reset($urandom_range(1, 2));
    end

    // Driver
    while (in_q.size() > 0) begin
      stim_t s;
      s = in_q.pop_front();
      @(posedge clk);
      #1;
      run = s.run; mem_ready = s.rdy; op = s.op;
      #1;
      rst = s.rst;  // lands mid-cycle to exercise the asynchronous path
      started = 1'b1;
    end
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: pending got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
